// File: rtl/led_pwm_multi.sv
// rtl/led_pwm_multi.sv - multi-channel LED dimmer: sigma-delta or counter-compare PWM drive with linear fade
module led_pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int RAMP_DIV   = 256,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                fade_en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic                period_start
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [WIDTH-1:0]    target [CHANNELS];
  logic [WIDTH-1:0]    level  [CHANNELS];
  logic [WIDTH-1:0]    duty   [CHANNELS];
  logic [WIDTH:0]      acc    [CHANNELS];
  logic [WIDTH-1:0]    cnt;
  logic [PW-1:0]       pre;
  logic                mode_q;
  logic                rdy;
  logic                wr_fire;
  logic                ramp_tick;
  logic                mode_chg;
  logic                cnt_last;
  logic [CHANNELS-1:0] led_raw;

  assign wr_ready  = rdy;
  assign wr_fire   = wr_valid && rdy;
  assign ramp_tick = (pre == PRE_LAST);
  assign mode_chg  = (mode != mode_q);
  assign cnt_last  = &cnt;

  // Drive source follows the live mode input so a mode switch shows on led one cycle later.
  always_comb begin
    busy    = '0;
    led_raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i]    = (level[i] != target[i]);
      led_raw[i] = mode ? (cnt < duty[i]) : acc[i][WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      pre          <= '0;
      mode_q       <= 1'b0;
      rdy          <= 1'b0;
      period_start <= 1'b0;
      led          <= {CHANNELS{ACTIVE_LOW}};
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        level[i]  <= '0;
        duty[i]   <= '0;
        acc[i]    <= '0;
      end
    end else begin
      rdy          <= 1'b1;
      cnt          <= cnt + 1'b1;
      period_start <= (cnt == '0);
      pre          <= ramp_tick ? '0 : pre + 1'b1;
      mode_q       <= mode;
      led          <= led_raw ^ {CHANNELS{ACTIVE_LOW}};
      for (int i = 0; i < CHANNELS; i++) begin
        // Out-of-range channel indices match no entry, so the write is simply dropped.
        if (wr_fire && (wr_ch == CH_W'(i)))
          target[i] <= wr_data;
        if (!fade_en)
          level[i] <= target[i];
        else if (ramp_tick) begin
          if (level[i] < target[i])
            level[i] <= level[i] + 1'b1;
          else if (level[i] > target[i])
            level[i] <= level[i] - 1'b1;
        end
        acc[i] <= mode_chg ? '0 : ({1'b0, acc[i][WIDTH-1:0]} + {1'b0, level[i]});
        if (cnt_last)
          duty[i] <= level[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_multi.sv
// tb/tb_led_pwm_multi.sv - directed, table-driven and randomized checks of led_pwm_multi
module tb_led_pwm_multi;

  localparam int W    = 4;
  localparam int NCH  = 2;
  localparam int CHW  = 2;
  localparam int RDIV = 4;
  localparam int LV   = 1 << W;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic           fade_en;
  logic           wr_valid;
  logic           wr_ready;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_data;
  logic [NCH-1:0] led;
  logic [NCH-1:0] busy;
  logic           period_start;

  int n_vec = 0;
  int n_bad = 0;

  led_pwm_multi #(
    .WIDTH(W), .CHANNELS(NCH), .CH_W(CHW), .RAMP_DIV(RDIV), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .fade_en(fade_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_data(wr_data),
    .led(led), .busy(busy), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Reference state: m_sum is the running brightness total, a carry past LV emits a pulse.
  int m_tgt[NCH], m_lvl[NCH], m_sum[NCH], m_duty[NCH], m_led[NCH];
  int m_cnt, m_pre, m_ps, m_prev_mode, m_rdy;

  typedef struct {
    int ch;
    int data;
    int busy_now;
  } wvec_t;
  wvec_t wtab[7];

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, fire;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_tgt[c] = 0; m_lvl[c] = 0; m_sum[c] = 0; m_duty[c] = 0; m_led[c] = 0;
      end
      m_cnt = 0; m_pre = 0; m_ps = 0; m_prev_mode = 0; m_rdy = 0;
      return;
    end
    fire = wr_valid && (m_rdy != 0);
    tick = (m_pre == RDIV - 1);
    for (int c = 0; c < NCH; c++) begin
      m_led[c] = mode ? int'(m_cnt < m_duty[c]) : int'(m_sum[c] >= LV);
      m_sum[c] = (int'(mode) != m_prev_mode) ? 0 : (m_sum[c] % LV) + m_lvl[c];
      if (m_cnt == LV - 1) m_duty[c] = m_lvl[c];
      if (!fade_en) m_lvl[c] = m_tgt[c];
      else if (tick && m_lvl[c] < m_tgt[c]) m_lvl[c] = m_lvl[c] + 1;
      else if (tick && m_lvl[c] > m_tgt[c]) m_lvl[c] = m_lvl[c] - 1;
      if (fire && int'(wr_ch) == c) m_tgt[c] = int'(wr_data);
    end
    m_ps = (m_cnt == 0) ? 1 : 0;
    m_cnt = (m_cnt + 1) % LV;
    m_pre = tick ? 0 : m_pre + 1;
    m_prev_mode = int'(mode);
    m_rdy = 1;
  endtask

  task automatic check_model();
    int el, eb;
    el = 0;
    eb = 0;
    for (int c = 0; c < NCH; c++) begin
      el = el | (m_led[c] << c);
      if (m_lvl[c] != m_tgt[c]) eb = eb | (1 << c);
    end
    check("model_led", int'(led), el);
    check("model_busy", int'(busy), eb);
    check("model_period_start", int'(period_start), m_ps);
    check("model_wr_ready", int'(wr_ready), m_rdy);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_write(int ch, int data);
    wr_valid = 1'b1;
    wr_ch    = CHW'(ch);
    wr_data  = W'(data);
    check("write_ready", int'(wr_ready), 1);
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps(string name, int max);
    int n = 0;
    while (!period_start && n < max) begin
      cyc();
      n++;
    end
    check(name, int'(period_start), 1);
  endtask

  task automatic align_tick();
    int n = 0;
    while (m_pre != RDIV - 1 && n < 2 * RDIV) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int hi, last, mingap, cnt1, found;

    wtab[0] = '{0, 5, 1};
    wtab[1] = '{1, 12, 2};
    wtab[2] = '{0, 5, 0};
    wtab[3] = '{3, 9, 0};
    wtab[4] = '{1, 0, 2};
    wtab[5] = '{2, 7, 0};
    wtab[6] = '{0, 0, 1};

    rst = 1'b1; mode = 1'b0; fade_en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_data = '0;
    cyc();
    cyc();
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    cyc();
    check("wr_ready_after_rst", int'(wr_ready), 1);

    // Table: target writes with immediate follow; busy flags only the written in-range channel.
    for (int i = 0; i < 7; i++) begin
      do_write(wtab[i].ch, wtab[i].data);
      check("tab_busy_now", int'(busy), wtab[i].busy_now);
      cyc();
      check("tab_busy_settled", int'(busy), 0);
    end

    // Sigma-delta density and spacing at level 5 of 16.
    do_write(0, 5);
    repeat (20) cyc();
    hi = 0; last = -100; mingap = 1000; cnt1 = 0;
    for (int k = 0; k < 160; k++) begin
      cyc();
      if (led[0]) begin
        if (k - last < mingap) mingap = k - last;
        last = k;
        hi++;
      end
      if (led[1]) cnt1++;
    end
    check("sd_highs", hi, 50);
    check("sd_min_gap", (mingap >= 3) ? 3 : mingap, 3);
    check("sd_ch1_dark", cnt1, 0);

    // PWM: mid-period write holds old duty until the wrap.
    mode = 1'b1;
    wait_ps("pwm_wait_ps", 20);
    repeat (7) cyc();
    do_write(1, 12);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      cyc();
      if (period_start) found = 1;
      else check("pwm_old_duty", int'(led[1]), 0);
    end
    check("pwm_wrap_seen", found, 1);
    for (int k = 0; k < 48; k++) begin
      if (k > 0) cyc();
      check("pwm_led1", int'(led[1]), ((k % 16) < 12) ? 1 : 0);
      check("pwm_period_start", int'(period_start), ((k % 16) == 0) ? 1 : 0);
    end

    // Fade up 0 -> 3 with the write landing on a tick edge, then down 3 -> 1.
    do_write(0, 0);
    cyc();
    cyc();
    fade_en = 1'b1;
    align_tick();
    do_write(0, 3);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) cyc();
      check("fade_up_level", int'(dut.level[0]), (k / 4 > 3) ? 3 : k / 4);
      check("fade_up_busy", int'(busy[0]), (k < 12) ? 1 : 0);
    end
    align_tick();
    do_write(0, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      check("fade_dn_level", int'(dut.level[0]), 3 - ((k / 4 > 2) ? 2 : k / 4));
      check("fade_dn_busy", int'(busy[0]), (k < 8) ? 1 : 0);
    end

    // Out-of-range channel write completes and is discarded.
    fade_en = 1'b0;
    cyc();
    do_write(3, 9);
    check("oob_target0", int'(dut.target[0]), 1);
    check("oob_target1", int'(dut.target[1]), 12);
    check("oob_busy", int'(busy), 0);
    cyc();
    check("oob_busy_later", int'(busy), 0);

    // Sigma-delta at level 7, then switch to PWM mid-period.
    mode = 1'b0;
    do_write(0, 7);
    repeat (40) cyc();
    wait_ps("mode_wait_ps", 20);
    repeat (5) cyc();
    mode = 1'b1;
    cyc();
    check("mode_acc0_clear", int'(dut.acc[0]), 0);
    check("mode_acc1_clear", int'(dut.acc[1]), 0);
    wait_ps("mode_wait_ps2", 20);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cyc();
      check("mode_pwm_led0", int'(led[0]), (k < 7) ? 1 : 0);
    end

    // Reset during an active fade and a PWM high phase.
    fade_en = 1'b1;
    do_write(0, 15);
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      cyc();
      if (led[0] && busy[0]) found = 1;
    end
    check("rst_mid_fade_reached", found, 1);
    rst = 1'b1;
    cyc();
    check("rst_mid_led", int'(led), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_wr_ready", int'(wr_ready), 0);
    rst = 1'b0;
    cyc();
    check("rst_mid_wr_ready_after", int'(wr_ready), 1);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (led != '0 || busy != '0) hi++;
    end
    check("rst_mid_dark_cycles", hi, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 59) == 0) fade_en = ~fade_en;
      wr_valid = 1'($urandom_range(0, 1));
      wr_ch    = CHW'($urandom_range(0, 3));
      wr_data  = W'($urandom_range(0, LV - 1));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
